ftb_bpu_pipe: RTL and testbench
===============================

// Module: ftb_bpu_pipe
// PURPOSE
//  Two-stage branch predictor with an internal direct-mapped FTB. Each cycle it issues one fetch-block
//  prediction (start, end, taken, target, FTB meta) to the FTQ, redirects its own PC on FTB hits and
//  accepts backend squash and FTB update. Sits between the backend redirect/commit paths and the FTQ.
// PARAMETERS
//  XLEN        64            address width
//  FETCH_BYTES 32            fetch block size in bytes, power of 2; OFB = log2(FETCH_BYTES)
//  FTB_SETS    256           FTB entries, power of 2; IDB = log2(FTB_SETS)
//  TAG_BITS    16            tag width; tag = pc[OFB+IDB +: TAG_BITS], index = pc[OFB +: IDB]
//  CTR_BITS    2             saturating direction counter width
//  INIT_PC     'h8000_0000   PC after reset
// PORTS
//  clk            in   1         clock
//  rst            in   1         synchronous, active-high reset
//  i_squash_vld   in   1         backend redirect
//  i_squash_pc    in   XLEN      redirect target
//  i_upd_vld      in   1         FTB write request (always accepted, 1 cycle)
//  i_upd_pc       in   XLEN      fetch block start PC being trained
//  i_upd_hit      in   1         block hit in FTB when predicted
//  i_upd_taken    in   1         resolved direction
//  i_upd_ctr      in   CTR_BITS  counter value returned in prediction meta
//  i_upd_fthru    in   OFB+1     fallthrough offset from block start, 1..FETCH_BYTES
//  i_upd_target   in   XLEN      branch target
//  i_upd_brtype   in   2         branch type, stored opaque
//  i_ftq_rdy      in   1         FTQ accepts o_pred_* this cycle
//  o_pred_vld     out  1         prediction valid
//  o_pred_start   out  XLEN      block start PC
//  o_pred_end     out  XLEN      last byte of block (fallthrough - 1)
//  o_pred_taken   out  1         predicted taken
//  o_pred_target  out  XLEN      stored target (0 on miss)
//  o_pred_hit     out  1         FTB hit
//  o_pred_brtype  out  2         stored branch type (0 on miss)
//  o_pred_ctr     out  CTR_BITS  stored counter (0 on miss)
// BEHAVIOUR
//  - Reset: pc0 = INIT_PC. S1/S2 valid = 0. All FTB valid bits = 0 (flop vector). o_pred_vld = 0,
//    all other outputs 0.
//  - S0: pc0 reads the FTB array (registered read). S1 holds pc/entry. S2 compares tags and drives
//    outputs. Latency pc0 -> o_pred_vld = 2 cycles.
//  - stall = S2 valid & !i_ftq_rdy. On stall every stage holds and outputs are stable.
//    Transfer occurs only when o_pred_vld & i_ftq_rdy.
//  - Miss: seq(pc) = (pc & ~(FETCH_BYTES-1)) + FETCH_BYTES. end = seq - 1, taken = 0.
//  - Hit (valid & tag match): fthru = start + entry.fthru. taken = ctr >= 2**(CTR_BITS-1).
//    npc = taken ? target : fthru. end = fthru - 1.
//  - Self-redirect: on S2 hit transfer with npc != S1 pc (or S1 invalid): pc0 <= npc, S1 killed.
//    This gives a one-bubble cycle. If npc == S1 pc, no redirect.
//  - Otherwise pc0 <= seq(pc0) when S0 advances.
//  - Update: single write port shared with lookup. An update cycle blocks the S0 read, so S1 gets a
//    bubble and pc0 holds. Written entry: valid = 1, tag/fthru/target/brtype from inputs.
//    New ctr = i_upd_hit ? sat(i_upd_ctr +/- 1 by i_upd_taken)
//                        : (i_upd_taken ? 2**(CTR_BITS-1) : 2**(CTR_BITS-1)-1).
//    Read and write to the same index in one cycle cannot occur (update wins).
//    A lookup issued the cycle after the write sees the new entry.
//  - Squash: highest priority, overrides stall and self-redirect. pc0 <= i_squash_pc; S1/S2 cleared.
//    o_pred_vld = 0 the next cycle; the first new prediction appears 2 cycles after resumption.
//    Squash and update in the same cycle: both take effect.
//  - All PC arithmetic is modulo 2**XLEN (wrap at top of address space, no error).
// TESTING
//  1 Reset, FTB cold, i_ftq_rdy=1 -> starts 0x8000_0000, 0x8000_0020, 0x8000_0040, end=start+0x1F, hit=0
//  2 Update pc=0x8000_0040, hit=0, taken=1, fthru=0x10, target=0x8000_1000, then squash to 0x8000_0040
//      -> pred start=0x8000_0040, end=0x8000_004F, taken=1, ctr=2; one bubble; next start=0x8000_1000
//  3 Three updates same block hit=1, taken=0, ctr fed back 2,1,0 -> ctr 1,0,0 (saturates); taken=0,
//      next start = 0x8000_0050
//  4 Hold i_ftq_rdy=0 for 5 cycles with o_pred_vld=1 -> outputs unchanged, no PC lost;
//      sequence resumes in order
//  5 Squash to 0x1234 during stall -> o_pred_vld=0 next cycle; then start=0x1234, end=0x123F,
//      next start=0x1240
//  6 pc0 = 2**XLEN-0x20 on cold FTB -> next start wraps to 0x0

Source files
------------

// File: rtl/ftb_bpu_pipe_if.sv
// Port bundle between the branch predictor, the backend redirect/commit paths and the FTQ.
// The slave modport is the predictor; the master modport is its environment.
interface ftb_bpu_pipe_if #(
  parameter int XLEN     = 64,
  parameter int OFB      = 5,
  parameter int CTR_BITS = 2
);
  logic                i_squash_vld;
  logic [XLEN-1:0]     i_squash_pc;
  logic                i_upd_vld;
  logic [XLEN-1:0]     i_upd_pc;
  logic                i_upd_hit;
  logic                i_upd_taken;
  logic [CTR_BITS-1:0] i_upd_ctr;
  logic [OFB:0]        i_upd_fthru;
  logic [XLEN-1:0]     i_upd_target;
  logic [1:0]          i_upd_brtype;
  logic                i_ftq_rdy;
  logic                o_pred_vld;
  logic [XLEN-1:0]     o_pred_start;
  logic [XLEN-1:0]     o_pred_end;
  logic                o_pred_taken;
  logic [XLEN-1:0]     o_pred_target;
  logic                o_pred_hit;
  logic [1:0]          o_pred_brtype;
  logic [CTR_BITS-1:0] o_pred_ctr;

  modport slave (
    input  i_squash_vld, i_squash_pc,
    input  i_upd_vld, i_upd_pc, i_upd_hit, i_upd_taken, i_upd_ctr,
    input  i_upd_fthru, i_upd_target, i_upd_brtype,
    input  i_ftq_rdy,
    output o_pred_vld, o_pred_start, o_pred_end, o_pred_taken,
    output o_pred_target, o_pred_hit, o_pred_brtype, o_pred_ctr
  );

  modport master (
    output i_squash_vld, i_squash_pc,
    output i_upd_vld, i_upd_pc, i_upd_hit, i_upd_taken, i_upd_ctr,
    output i_upd_fthru, i_upd_target, i_upd_brtype,
    output i_ftq_rdy,
    input  o_pred_vld, o_pred_start, o_pred_end, o_pred_taken,
    input  o_pred_target, o_pred_hit, o_pred_brtype, o_pred_ctr
  );
endinterface

// File: rtl/ftb_bpu_pipe.sv
// Two-stage fetch-block predictor: S0 reads a direct-mapped FTB, S1 holds pc/entry,
// S2 registers the tag-compared prediction toward the FTQ and steers pc0 on hits.
module ftb_bpu_pipe #(
  parameter int              XLEN        = 64,
  parameter int              FETCH_BYTES = 32,
  parameter int              FTB_SETS    = 256,
  parameter int              TAG_BITS    = 16,
  parameter int              CTR_BITS    = 2,
  parameter logic [XLEN-1:0] INIT_PC     = 64'h0000_0000_8000_0000
) (
  input  logic           clk,
  input  logic           rst,
  ftb_bpu_pipe_if.slave  bus
);
  localparam int OFB = $clog2(FETCH_BYTES);
  localparam int IDB = $clog2(FTB_SETS);
  localparam logic [XLEN-1:0]     FB_SZ    = XLEN'(FETCH_BYTES);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_WT   = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0] CTR_WNT  = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_ZERO = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0] CTR_ONE  = {{(CTR_BITS-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [TAG_BITS-1:0] tag;
    logic [OFB:0]        fthru;
    logic [XLEN-1:0]     target;
    logic [1:0]          brtype;
    logic [CTR_BITS-1:0] ctr;
  } entry_t;

  function automatic logic [CTR_BITS-1:0] next_ctr(input logic hit, input logic taken,
                                                   input logic [CTR_BITS-1:0] ctr);
    logic [CTR_BITS-1:0] res;
    if (hit) begin
      if (taken) res = (ctr == CTR_MAX)  ? ctr : ctr + CTR_ONE;
      else       res = (ctr == CTR_ZERO) ? ctr : ctr - CTR_ONE;
    end else begin
      res = taken ? CTR_WT : CTR_WNT;
    end
    return res;
  endfunction

  function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:OFB], {OFB{1'b0}}} + FB_SZ;
  endfunction

  entry_t                ftb_mem_q [FTB_SETS];
  logic [FTB_SETS-1:0]   ftb_vld_q;

  logic [XLEN-1:0]       pc0_q, pc0_d;
  logic                  s1_vld_q, s1_vld_d;
  logic [XLEN-1:0]       s1_pc_q;
  entry_t                s1_ent_q;
  logic                  s1_ent_vld_q;
  logic                  s2_vld_q, s2_vld_d;

  logic [XLEN-1:0]       pred_start_q, pred_end_q, pred_target_q;
  logic                  pred_taken_q, pred_hit_q;
  logic [1:0]            pred_brtype_q;
  logic [CTR_BITS-1:0]   pred_ctr_q;

  logic                  stall_s, advance_s, s0_rd_s, redirect_s;
  logic                  s1_hit_s, s1_taken_s;
  logic [XLEN-1:0]       s1_seq_s, s1_fthru_s, s1_npc_s, s1_end_s;
  logic [IDB-1:0]        rd_idx_s, upd_idx_s;
  entry_t                upd_ent_s;
  logic                  upd_pc_unused_s;

  assign stall_s   = s2_vld_q & ~bus.i_ftq_rdy;
  assign advance_s = ~stall_s;
  // An update owns the single array port, so the lookup for pc0 waits a cycle.
  assign s0_rd_s   = advance_s & ~bus.i_upd_vld;
  assign rd_idx_s  = pc0_q[OFB +: IDB];
  assign upd_idx_s = bus.i_upd_pc[OFB +: IDB];

  assign s1_hit_s   = s1_vld_q & s1_ent_vld_q &
                      (s1_ent_q.tag == s1_pc_q[OFB+IDB +: TAG_BITS]);
  assign s1_taken_s = s1_hit_s & s1_ent_q.ctr[CTR_BITS-1];
  assign s1_seq_s   = seq_pc(s1_pc_q);
  assign s1_fthru_s = s1_pc_q + XLEN'(s1_ent_q.fthru);
  assign s1_npc_s   = s1_taken_s ? s1_ent_q.target : s1_fthru_s;
  assign s1_end_s   = (s1_hit_s ? s1_fthru_s : s1_seq_s) - {{(XLEN-1){1'b0}}, 1'b1};
  // pc0 already holds the block fetched after S1, so a redirect is needed only if it disagrees.
  assign redirect_s = advance_s & s1_hit_s & (s1_npc_s != pc0_q);

  assign upd_ent_s.tag    = bus.i_upd_pc[OFB+IDB +: TAG_BITS];
  assign upd_ent_s.fthru  = bus.i_upd_fthru;
  assign upd_ent_s.target = bus.i_upd_target;
  assign upd_ent_s.brtype = bus.i_upd_brtype;
  assign upd_ent_s.ctr    = next_ctr(bus.i_upd_hit, bus.i_upd_taken, bus.i_upd_ctr);
  assign upd_pc_unused_s  = ^{bus.i_upd_pc[XLEN-1:OFB+IDB+TAG_BITS], bus.i_upd_pc[OFB-1:0]};

  // Next-state for fetch PC and stage valids; squash beats stall and self-redirect.
  always_comb begin
    pc0_d    = pc0_q;
    s1_vld_d = s1_vld_q;
    s2_vld_d = s2_vld_q;
    if (bus.i_squash_vld) begin
      pc0_d    = bus.i_squash_pc;
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
    end else if (advance_s) begin
      s2_vld_d = s1_vld_q;
      if (redirect_s) begin
        pc0_d    = s1_npc_s;
        s1_vld_d = 1'b0;
      end else if (s0_rd_s) begin
        pc0_d    = seq_pc(pc0_q);
        s1_vld_d = 1'b1;
      end else begin
        s1_vld_d = 1'b0;
      end
    end else begin
      pc0_d    = pc0_q;
    end
  end

  // FTB payload array; only the valid bits need a reset.
  always_ff @(posedge clk) begin
    if (bus.i_upd_vld) begin
      ftb_mem_q[upd_idx_s] <= upd_ent_s;
    end
  end

  // Pipeline registers, FTB valid vector and registered prediction outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc0_q         <= INIT_PC;
      s1_vld_q      <= 1'b0;
      s2_vld_q      <= 1'b0;
      s1_pc_q       <= '0;
      s1_ent_q      <= '0;
      s1_ent_vld_q  <= 1'b0;
      ftb_vld_q     <= '0;
      pred_start_q  <= '0;
      pred_end_q    <= '0;
      pred_target_q <= '0;
      pred_taken_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_brtype_q <= 2'b00;
      pred_ctr_q    <= '0;
    end else begin
      pc0_q    <= pc0_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      if (bus.i_upd_vld) begin
        ftb_vld_q[upd_idx_s] <= 1'b1;
      end
      if (s0_rd_s) begin
        s1_pc_q      <= pc0_q;
        s1_ent_q     <= ftb_mem_q[rd_idx_s];
        s1_ent_vld_q <= ftb_vld_q[rd_idx_s];
      end
      if (advance_s && !bus.i_squash_vld && s1_vld_q) begin
        pred_start_q  <= s1_pc_q;
        pred_end_q    <= s1_end_s;
        pred_taken_q  <= s1_taken_s;
        pred_hit_q    <= s1_hit_s;
        pred_target_q <= s1_hit_s ? s1_ent_q.target : '0;
        pred_brtype_q <= s1_hit_s ? s1_ent_q.brtype : 2'b00;
        pred_ctr_q    <= s1_hit_s ? s1_ent_q.ctr    : '0;
      end
    end
  end

  assign bus.o_pred_vld    = s2_vld_q;
  assign bus.o_pred_start  = pred_start_q;
  assign bus.o_pred_end    = pred_end_q;
  assign bus.o_pred_taken  = pred_taken_q;
  assign bus.o_pred_target = pred_target_q;
  assign bus.o_pred_hit    = pred_hit_q;
  assign bus.o_pred_brtype = pred_brtype_q;
  assign bus.o_pred_ctr    = pred_ctr_q;
endmodule

// File: tb/tb_ftb_bpu_pipe.sv
// Directed bench for ftb_bpu_pipe: a table for the cold sequential stream, hand-written
// sequences for update, saturation, stall, squash and address wrap.
module tb_ftb_bpu_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ftb_bpu_pipe_if bus ();
  ftb_bpu_pipe dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rdy;
    logic        exp_vld;
    logic [63:0] exp_start;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pred(input string name, input logic [63:0] start, input logic [63:0] endp,
                             input logic taken, input logic [63:0] tgt, input logic hit,
                             input logic [1:0] ctr, input logic [1:0] brt);
    chk({name, ".vld"},    64'(bus.o_pred_vld),    64'd1);
    chk({name, ".start"},  bus.o_pred_start,       start);
    chk({name, ".end"},    bus.o_pred_end,         endp);
    chk({name, ".taken"},  64'(bus.o_pred_taken),  64'(taken));
    chk({name, ".target"}, bus.o_pred_target,      tgt);
    chk({name, ".hit"},    64'(bus.o_pred_hit),    64'(hit));
    chk({name, ".ctr"},    64'(bus.o_pred_ctr),    64'(ctr));
    chk({name, ".brtype"}, 64'(bus.o_pred_brtype), 64'(brt));
  endtask

  task automatic upd(input logic [63:0] pc, input logic hit, input logic taken,
                     input logic [1:0] ctr, input logic [5:0] fthru,
                     input logic [63:0] tgt, input logic [1:0] brt);
    bus.i_upd_vld    = 1'b1;
    bus.i_upd_pc     = pc;
    bus.i_upd_hit    = hit;
    bus.i_upd_taken  = taken;
    bus.i_upd_ctr    = ctr;
    bus.i_upd_fthru  = fthru;
    bus.i_upd_target = tgt;
    bus.i_upd_brtype = brt;
    step();
    bus.i_upd_vld    = 1'b0;
  endtask

  task automatic restart(input string name, input logic [63:0] pc);
    bus.i_squash_vld = 1'b1;
    bus.i_squash_pc  = pc;
    step();
    chk({name, ".sq_vld0"}, 64'(bus.o_pred_vld), 64'd0);
    bus.i_squash_vld = 1'b0;
    step();
    chk({name, ".sq_vld1"}, 64'(bus.o_pred_vld), 64'd0);
    step();
  endtask

  initial begin
    tbl[0] = '{rdy: 1'b1, exp_vld: 1'b0, exp_start: 64'h0};
    tbl[1] = '{rdy: 1'b1, exp_vld: 1'b1, exp_start: 64'h8000_0000};
    tbl[2] = '{rdy: 1'b1, exp_vld: 1'b1, exp_start: 64'h8000_0020};
    tbl[3] = '{rdy: 1'b1, exp_vld: 1'b1, exp_start: 64'h8000_0040};
    tbl[4] = '{rdy: 1'b1, exp_vld: 1'b1, exp_start: 64'h8000_0060};

    rst = 1'b1;
    bus.i_squash_vld = 1'b0; bus.i_squash_pc = 64'h0;
    bus.i_upd_vld = 1'b0; bus.i_upd_pc = 64'h0; bus.i_upd_hit = 1'b0; bus.i_upd_taken = 1'b0;
    bus.i_upd_ctr = 2'd0; bus.i_upd_fthru = 6'd0; bus.i_upd_target = 64'h0; bus.i_upd_brtype = 2'd0;
    bus.i_ftq_rdy = 1'b1;
    repeat (3) step();
    chk("reset.vld",    64'(bus.o_pred_vld), 64'd0);
    chk("reset.start",  bus.o_pred_start,    64'h0);
    chk("reset.end",    bus.o_pred_end,      64'h0);
    chk("reset.target", bus.o_pred_target,   64'h0);
    rst = 1'b0;

    // Cold FTB sequential stream
    for (int i = 0; i < 5; i++) begin
      bus.i_ftq_rdy = tbl[i].rdy;
      step();
      chk($sformatf("cold%0d.vld", i), 64'(bus.o_pred_vld), 64'(tbl[i].exp_vld));
      if (tbl[i].exp_vld) begin
        expect_pred($sformatf("cold%0d", i), tbl[i].exp_start, tbl[i].exp_start + 64'h1F,
                    1'b0, 64'h0, 1'b0, 2'd0, 2'd0);
      end
    end

    // New taken entry, then refetch it: hit, one bubble, jump to target
    upd(64'h8000_0040, 1'b0, 1'b1, 2'd0, 6'h10, 64'h8000_1000, 2'd2);
    restart("t2", 64'h8000_0040);
    expect_pred("t2.a", 64'h8000_0040, 64'h8000_004F, 1'b1, 64'h8000_1000, 1'b1, 2'd2, 2'd2);
    step();
    chk("t2.bubble", 64'(bus.o_pred_vld), 64'd0);
    step();
    expect_pred("t2.tgt", 64'h8000_1000, 64'h8000_101F, 1'b0, 64'h0, 1'b0, 2'd0, 2'd0);

    // Counter training toward not-taken, with saturation at zero
    upd(64'h8000_0040, 1'b1, 1'b0, 2'd2, 6'h10, 64'h8000_1000, 2'd2);
    restart("t3a", 64'h8000_0040);
    expect_pred("t3a", 64'h8000_0040, 64'h8000_004F, 1'b0, 64'h8000_1000, 1'b1, 2'd1, 2'd2);
    step();
    chk("t3a.bubble", 64'(bus.o_pred_vld), 64'd0);
    step();
    expect_pred("t3a.ft", 64'h8000_0050, 64'h8000_005F, 1'b0, 64'h8000_1000, 1'b1, 2'd1, 2'd2);
    step();
    expect_pred("t3a.seq", 64'h8000_0060, 64'h8000_007F, 1'b0, 64'h0, 1'b0, 2'd0, 2'd0);
    upd(64'h8000_0040, 1'b1, 1'b0, 2'd1, 6'h10, 64'h8000_1000, 2'd2);
    upd(64'h8000_0040, 1'b1, 1'b0, 2'd0, 6'h10, 64'h8000_1000, 2'd2);
    restart("t3b", 64'h8000_0040);
    expect_pred("t3b", 64'h8000_0040, 64'h8000_004F, 1'b0, 64'h8000_1000, 1'b1, 2'd0, 2'd2);

    // FTQ back-pressure for five cycles
    restart("t4", 64'h8000_2000);
    expect_pred("t4.a", 64'h8000_2000, 64'h8000_201F, 1'b0, 64'h0, 1'b0, 2'd0, 2'd0);
    bus.i_ftq_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t4.hold%0d.vld", i), 64'(bus.o_pred_vld), 64'd1);
      chk($sformatf("t4.hold%0d.start", i), bus.o_pred_start, 64'h8000_2000);
    end
    bus.i_ftq_rdy = 1'b1;
    step();
    expect_pred("t4.b", 64'h8000_2020, 64'h8000_203F, 1'b0, 64'h0, 1'b0, 2'd0, 2'd0);
    step();
    expect_pred("t4.c", 64'h8000_2040, 64'h8000_205F, 1'b0, 64'h0, 1'b0, 2'd0, 2'd0);

    // Squash while stalled
    bus.i_ftq_rdy = 1'b0;
    bus.i_squash_vld = 1'b1;
    bus.i_squash_pc = 64'h1234;
    step();
    chk("t5.vld0", 64'(bus.o_pred_vld), 64'd0);
    bus.i_squash_vld = 1'b0;
    bus.i_ftq_rdy = 1'b1;
    step();
    chk("t5.vld1", 64'(bus.o_pred_vld), 64'd0);
    step();
    expect_pred("t5.a", 64'h1234, 64'h123F, 1'b0, 64'h0, 1'b0, 2'd0, 2'd0);
    step();
    expect_pred("t5.b", 64'h1240, 64'h125F, 1'b0, 64'h0, 1'b0, 2'd0, 2'd0);

    // Wrap at the top of the address space
    restart("t6", 64'hFFFF_FFFF_FFFF_FFE0);
    expect_pred("t6.a", 64'hFFFF_FFFF_FFFF_FFE0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, 1'b0, 2'd0, 2'd0);
    step();
    expect_pred("t6.b", 64'h0, 64'h1F, 1'b0, 64'h0, 1'b0, 2'd0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
